rs232_cmd_parser: RTL
=====================

Name: rs232_cmd_parser

Overview:
- Consumes the byte stream of the RS-232 receive controller: `rx_val`, `rx_bits`, `rx_error`.
- Parses ASCII hex command lines into register read/write requests for the LCD/debug register space.
- Each request is presented on a valid/ready command port.
- Framing errors and malformed lines resynchronise the parser at end of line.

Parameters:
- ADDR_W, 8, address width in bits; multiple of 4; max address digits = ADDR_W/4.
- DATA_W, 32, data width in bits; multiple of 4; max data digits = DATA_W/4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- rx_val  in  1  one-cycle strobe: rx_bits holds a received byte
- rx_bits  in  8  received byte, valid only with rx_val
- rx_error  in  1  one-cycle strobe: stop-bit framing error
- cmd_val  out  1  command valid
- cmd_ready  in  1  consumer accepts command
- cmd_we  out  1  1 = write, 0 = read
- cmd_addr  out  ADDR_W  command address
- cmd_data  out  DATA_W  write data; 0 for reads
- parse_err  out  1  one-cycle pulse on malformed line or framing error
- overrun  out  1  sticky: a byte was dropped while a command was pending
- ovr_clr  in  1  clears overrun

Behaviour:
- Grammar:
  - Write line: `W|w <addr hex> SP <data hex> CR|LF`
  - Read line: `R|r <addr hex> CR|LF`
  - Hex digits are 0-9, A-F, a-f. Accumulation is shift-left-by-4 OR digit, MSB first.
  - Fewer digits than the maximum are zero-extended.
- Reset (`rst` = 0, async): state IDLE, `cmd_val` = 0, `cmd_we` = 0, `cmd_addr` = 0, `cmd_data` = 0, `parse_err` = 0, `overrun` = 0, digit counters = 0.
- FSM states: IDLE, ADDR, DATA, ISSUE, ERR. Bytes are evaluated only on cycles with `rx_val` = 1.
- IDLE:
  - `W`/`w` → ADDR, `cmd_we` = 1; `R`/`r` → ADDR, `cmd_we` = 0.
  - On either command letter, `cmd_addr` and `cmd_data` are cleared and the counters reset.
  - CR, LF and SP are ignored. Any other byte → ERR.
- ADDR:
  - A hex digit is accumulated into `cmd_addr`.
  - A digit beyond ADDR_W/4 digits → ERR.
  - SP with ≥1 digit and `cmd_we` = 1 → DATA.
  - CR/LF with ≥1 digit and `cmd_we` = 0 → ISSUE.
  - Anything else → ERR, including SP on a read, CR/LF on a write, and a terminator with 0 digits.
- DATA:
  - A hex digit is accumulated into `cmd_data`.
  - A digit beyond DATA_W/4 digits → ERR.
  - CR/LF with ≥1 digit → ISSUE. Anything else → ERR.
- ISSUE:
  - `cmd_val` = 1 (registered; asserted the cycle after the terminator byte).
  - `cmd_we`, `cmd_addr` and `cmd_data` are held stable while `cmd_val` = 1.
  - Handshake completes on `cmd_val && cmd_ready` → IDLE, and `cmd_val` = 0 the next cycle.
  - `rx_val` in ISSUE without `cmd_ready`: byte dropped, `overrun` set.
  - `rx_val` with `cmd_ready` in the same cycle: handshake completes and the byte is evaluated under IDLE rules in that cycle; no overrun.
- ERR: discards bytes until CR/LF, then → IDLE.
- `parse_err` is a single-cycle pulse on every transition into ERR, from any state, and is registered.
- `rx_error` handling:
  - Any state except ISSUE → ERR with a `parse_err` pulse.
  - In ISSUE it sets `overrun`; the command is still issued.
  - When `rx_error` and `rx_val` coincide, `rx_error` wins.
- `overrun` is sticky until `ovr_clr` = 1. If set and clear occur in the same cycle, set wins.
- Minimum latency from terminator `rx_val` to `cmd_val` is 1 cycle. No byte is ever lost outside ISSUE.

Optional Feature:
- Macro: RS232_CMD_ECHO_EN.
- Defined: adds output ports `echo_val` (1) and `echo_bits` (8).
  - `echo_val` pulses 1 cycle after every `rx_val` byte that is not dropped, with `echo_bits` = that byte.
  - CR is echoed as CR followed by LF on the next cycle, then `echo_val` = 0.
  - A byte arriving on the LF cycle is echoed after the LF, using a 1-deep holding register.
  - These outputs feed the transmit controller for terminal echo. Reset values are 0.
- Undefined: the ports are absent and no echo logic is generated.

Decomposition:
- Shared package holds the FSM enum `cmd_state_t`, ASCII constants (`CH_CR`, `CH_LF`, `CH_SP`), and the hex-decode function `hex2nib`, which returns valid + 4-bit value.
- One sub-module is natural: `rs232_hex_acc`, a parameterised digit accumulator with clear, shift-in, count and overflow flag. It is instantiated twice, for address and data.
- The FSM stays in the top-level module.

Test Plan:
- Send "W1A 0000BEEF\r", `cmd_ready` = 1 → single `cmd_val` pulse, `cmd_we` = 1, `cmd_addr` = 0x1A, `cmd_data` = 0x0000BEEF; `parse_err` = 0.
- Send "r7\n" with `cmd_ready` held 0 for 5 cycles → `cmd_val` high and stable with `cmd_we` = 0, `cmd_addr` = 0x07, `cmd_data` = 0 until `cmd_ready`; then IDLE.
- Send "W123 5\r" (3 address digits, ADDR_W = 8) → `parse_err` pulse at the third digit, no `cmd_val`; following "W05 1\r" → `cmd_addr` = 0x05, `cmd_data` = 0x1.
- Send "W2 G\r" → `parse_err` on 'G', line discarded; then `rx_error` pulse mid "R3" → `parse_err`, no command until the next valid line.
- Hold `cmd_ready` = 0 after "R4\r" and send 'X' → `overrun` = 1 and the command still issues. Pulse `ovr_clr` → `overrun` = 0. Assert `cmd_ready` in the same cycle as an 'R' byte → handshake completes and the parser enters ADDR.
- Assert `rst` low mid "W1 FF" → all outputs 0 immediately (async); after release "R9\n" parses normally with `cmd_addr` = 0x09.

Source files
------------

// File: rtl/rs232_cmd_parser_pkg.sv
// rtl/rs232_cmd_parser_pkg.sv - shared FSM states, ASCII constants and hex decode for the command parser
package rs232_cmd_parser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ISSUE = 3'd3,
        ERR   = 3'd4
    } cmd_state_t;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    // Returns {valid, nibble}; letters A-F/a-f share low nibble 1..6, hence the +9.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

endpackage

// File: rtl/rs232_cmd_parser_if.sv
// rtl/rs232_cmd_parser_if.sv - byte-in / command-out bundle for the parser; echo signals under RS232_CMD_ECHO_EN
interface rs232_cmd_parser_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rx_val;
    logic [7:0]        rx_bits;
    logic              rx_error;
    logic              cmd_val;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              parse_err;
    logic              overrun;
    logic              ovr_clr;
`ifdef RS232_CMD_ECHO_EN
    logic              echo_val;
    logic [7:0]        echo_bits;
`endif

    modport master (
        output rx_val, rx_bits, rx_error, cmd_ready, ovr_clr,
        input  cmd_val, cmd_we, cmd_addr, cmd_data, parse_err, overrun
`ifdef RS232_CMD_ECHO_EN
        , input echo_val, echo_bits
`endif
    );

    modport slave (
        input  rx_val, rx_bits, rx_error, cmd_ready, ovr_clr,
        output cmd_val, cmd_we, cmd_addr, cmd_data, parse_err, overrun
`ifdef RS232_CMD_ECHO_EN
        , output echo_val, echo_bits
`endif
    );

endinterface

// File: rtl/rs232_cmd_parser_hex_acc.sv
// rtl/rs232_cmd_parser_hex_acc.sv - rs232_hex_acc: MSB-first hex digit accumulator with digit count and full flag
module rs232_hex_acc #(
    parameter int  W  = 8,
    localparam int CW = $clog2(W/4 + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_shift,
    input  logic [3:0]    i_nib,
    output logic [W-1:0]  o_value,
    output logic [CW-1:0] o_count,
    output logic          o_ovf
);
    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;

    // o_ovf means one more digit would not fit; the parser rejects it rather than wrapping.
    assign o_ovf   = (r_count == CW'(W/4));
    assign o_value = r_value;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_shift && !o_ovf) begin
            r_value <= (r_value << 4) | W'(i_nib);
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rs232_cmd_parser.sv
// rtl/rs232_cmd_parser.sv - ASCII hex R/W line parser feeding a valid/ready command port; echo under RS232_CMD_ECHO_EN
module rs232_cmd_parser #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    rs232_cmd_parser_if.slave bus
);
    import rs232_cmd_parser_pkg::*;

    localparam int ACW = $clog2(ADDR_W/4 + 1);
    localparam int DCW = $clog2(DATA_W/4 + 1);

    cmd_state_t        r_state, w_next;
    logic              r_cmd_val, r_cmd_we, r_parse_err, r_overrun;
    logic              w_clr, w_addr_shift, w_data_shift, w_we_load, w_we_val;
    logic              w_err, w_ovr_set, w_idle_eval;
    logic [4:0]        w_hex;
    logic              w_is_term, w_is_sp;
    logic [ADDR_W-1:0] w_addr_val;
    logic [DATA_W-1:0] w_data_val;
    logic [ACW-1:0]    w_addr_cnt;
    logic [DCW-1:0]    w_data_cnt;
    logic              w_addr_ovf, w_data_ovf;

    assign w_hex     = hex2nib(bus.rx_bits);
    assign w_is_term = (bus.rx_bits == CH_CR) || (bus.rx_bits == CH_LF);
    assign w_is_sp   = (bus.rx_bits == CH_SP);

    rs232_hex_acc #(.W(ADDR_W)) u_addr_acc (
        .clk(clk), .rst_n(rst), .i_clr(w_clr), .i_shift(w_addr_shift), .i_nib(w_hex[3:0]),
        .o_value(w_addr_val), .o_count(w_addr_cnt), .o_ovf(w_addr_ovf)
    );

    rs232_hex_acc #(.W(DATA_W)) u_data_acc (
        .clk(clk), .rst_n(rst), .i_clr(w_clr), .i_shift(w_data_shift), .i_nib(w_hex[3:0]),
        .o_value(w_data_val), .o_count(w_data_cnt), .o_ovf(w_data_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cmd_val   <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_parse_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_val   <= (w_next == ISSUE);
            r_parse_err <= w_err;
            if (w_we_load)
                r_cmd_we <= w_we_val;
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (bus.ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_clr        = 1'b0;
        w_addr_shift = 1'b0;
        w_data_shift = 1'b0;
        w_we_load    = 1'b0;
        w_we_val     = 1'b0;
        w_err        = 1'b0;
        w_ovr_set    = 1'b0;
        w_idle_eval  = 1'b0;
        if (bus.rx_error && r_state != ISSUE) begin
            w_next = ERR;
            w_err  = 1'b1;
        end else begin
            case (r_state)
                IDLE: w_idle_eval = bus.rx_val;
                ADDR: if (bus.rx_val) begin
                    if (w_hex[4] && !w_addr_ovf)
                        w_addr_shift = 1'b1;
                    else if (w_is_sp && |w_addr_cnt && r_cmd_we)
                        w_next = DATA;
                    else if (w_is_term && |w_addr_cnt && !r_cmd_we)
                        w_next = ISSUE;
                    else begin
                        w_next = ERR;
                        w_err  = 1'b1;
                    end
                end
                DATA: if (bus.rx_val) begin
                    if (w_hex[4] && !w_data_ovf)
                        w_data_shift = 1'b1;
                    else if (w_is_term && |w_data_cnt)
                        w_next = ISSUE;
                    else begin
                        w_next = ERR;
                        w_err  = 1'b1;
                    end
                end
                // A byte in the handshake cycle is parsed as the start of the next line.
                ISSUE: begin
                    w_ovr_set = bus.rx_error || (bus.rx_val && !bus.cmd_ready);
                    if (bus.cmd_ready) begin
                        w_next      = IDLE;
                        w_idle_eval = bus.rx_val && !bus.rx_error;
                    end
                end
                ERR: if (bus.rx_val && w_is_term) w_next = IDLE;
                default: w_next = IDLE;
            endcase
            if (w_idle_eval) begin
                if (bus.rx_bits == "W" || bus.rx_bits == "w" ||
                    bus.rx_bits == "R" || bus.rx_bits == "r") begin
                    w_next    = ADDR;
                    w_clr     = 1'b1;
                    w_we_load = 1'b1;
                    w_we_val  = (bus.rx_bits == "W" || bus.rx_bits == "w");
                end else if (!(w_is_term || w_is_sp)) begin
                    w_next = ERR;
                    w_err  = 1'b1;
                end
            end
        end
    end

    assign bus.cmd_val   = r_cmd_val;
    assign bus.cmd_we    = r_cmd_we;
    assign bus.cmd_addr  = w_addr_val;
    assign bus.cmd_data  = w_data_val;
    assign bus.parse_err = r_parse_err;
    assign bus.overrun   = r_overrun;

`ifdef RS232_CMD_ECHO_EN
    logic       w_accept;
    logic       r_echo_val, r_lf_pend, r_hold_val;
    logic [7:0] r_echo_bits, r_hold_bits;

    assign w_accept = bus.rx_val && !bus.rx_error && !(r_state == ISSUE && !bus.cmd_ready);

    // The LF inserted after CR takes one slot; a byte colliding with it waits in r_hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_echo_val  <= 1'b0;
            r_echo_bits <= 8'h00;
            r_lf_pend   <= 1'b0;
            r_hold_val  <= 1'b0;
            r_hold_bits <= 8'h00;
        end else if (r_lf_pend) begin
            r_echo_val  <= 1'b1;
            r_echo_bits <= CH_LF;
            r_lf_pend   <= 1'b0;
            if (w_accept) begin
                r_hold_val  <= 1'b1;
                r_hold_bits <= bus.rx_bits;
            end
        end else if (r_hold_val) begin
            r_echo_val  <= 1'b1;
            r_echo_bits <= r_hold_bits;
            r_lf_pend   <= (r_hold_bits == CH_CR);
            r_hold_val  <= w_accept;
            if (w_accept)
                r_hold_bits <= bus.rx_bits;
        end else if (w_accept) begin
            r_echo_val  <= 1'b1;
            r_echo_bits <= bus.rx_bits;
            r_lf_pend   <= (bus.rx_bits == CH_CR);
        end else begin
            r_echo_val  <= 1'b0;
        end
    end

    assign bus.echo_val  = r_echo_val;
    assign bus.echo_bits = r_echo_bits;
`endif

endmodule
